// File: rtl/stop_timestamp_encoder.sv
// stop_timestamp_encoder: timestamps stop hits as {coarse, fine} into a small output FIFO, with dead-time FSM.
// Defining STOP_BUBBLE_CORR_EN switches the fine code from highest-set-bit to a bubble-tolerant popcount.
module stop_timestamp_encoder #(
  parameter int TAPS       = 64,
  parameter int COARSE_W   = 16,
  parameter int FINE_W     = $clog2(TAPS + 1),
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TAPS-1:0]            therm,
  input  logic                       valid,
  input  logic                       finish,
  output logic [COARSE_W+FINE_W-1:0] ts_data,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic                       proto_err,
  output logic [7:0]                 drop_cnt,
  output logic                       busy
);
  localparam int W  = COARSE_W + FINE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
  state_t              state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic                late_q, late_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                perr_q, perr_d;
  logic                busy_q, busy_d;
  logic [7:0]          drop_q, drop_d;
  logic                s1_vld_q, s1_vld_d;
  logic [TAPS-1:0]     s1_therm_q, s1_therm_d;
  logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;
  logic                s2_vld_q, s2_vld_d;
  logic [W-1:0]        s2_word_q, s2_word_d;
  logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
  logic                ovf_q, ovf_d;
  logic [W-1:0]        mem_q [FIFO_DEPTH];
  logic [FINE_W-1:0]   fine;
  logic                accept, empty, full, pop, wr_en;
`ifdef STOP_BUBBLE_CORR_EN
  localparam int P = 1 << $clog2(TAPS);
  logic [FINE_W-1:0] tree [1:2*P-1];
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < TAPS) begin : g_tap
      assign tree[P+i] = FINE_W'(s1_therm_q[i]);
    end else begin : g_pad
      assign tree[P+i] = '0;
    end
  end
  for (genvar i = 1; i < P; i++) begin : g_node
    assign tree[i] = tree[2*i] + tree[2*i+1];
  end
  assign fine = tree[1];
`else
  always_comb begin
    fine = '0;
    for (int i = 0; i < TAPS; i++) if (s1_therm_q[i]) fine = FINE_W'(i + 1);
  end
`endif
  always_comb begin
    accept  = valid && state_q == S_IDLE;
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    late_d  = late_q;
    hold_d  = hold_q;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: if (valid) begin
        state_d = S_WAIT;
        late_d  = 1'b0;
      end
      // finish is allowed in either of the two cycles after the accepted valid
      S_WAIT: if (finish || late_q) begin
        state_d = S_HOLD;
        hold_d  = '0;
        perr_d  = perr_q | ~finish;
      end else late_d = 1'b1;
      default: if (hold_q == HW'(HOLDOFF - 1)) state_d = S_IDLE;
               else hold_d = hold_q + 1'b1;
    endcase
    busy_d      = state_d != S_IDLE;
    drop_d      = (valid && state_q != S_IDLE && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    s1_vld_d    = accept;
    s1_therm_d  = accept ? therm : s1_therm_q;
    s1_coarse_d = accept ? cnt_q - 1'b1 : s1_coarse_q;
    s2_vld_d    = s1_vld_q;
    s2_word_d   = s1_vld_q ? {s1_coarse_q, fine} : s2_word_q;
    empty       = wr_q == rd_q;
    full        = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    pop         = !empty && ts_ready;
    wr_en       = s2_vld_q && (!full || pop);
    wr_d        = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d        = pop ? rd_q + 1'b1 : rd_q;
    ovf_d       = (s2_vld_q && !wr_en) || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      late_q      <= 1'b0;
      hold_q      <= '0;
      perr_q      <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_therm_q  <= '0;
      s1_coarse_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_word_q   <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      late_q      <= late_d;
      hold_q      <= hold_d;
      perr_q      <= perr_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      s1_vld_q    <= s1_vld_d;
      s1_therm_q  <= s1_therm_d;
      s1_coarse_q <= s1_coarse_d;
      s2_vld_q    <= s2_vld_d;
      s2_word_q   <= s2_word_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= s2_word_q;
  end
  assign ts_valid  = !empty;
  assign ts_data   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow  = ovf_q;
  assign proto_err = perr_q;
  assign drop_cnt  = drop_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_stop_timestamp_encoder.sv
// tb_stop_timestamp_encoder: table vectors, directed corner sequences and random traffic against a timing-level model.
module tb_stop_timestamp_encoder;
  localparam int HOLDOFF = 4;
  localparam int DEPTH   = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] therm = '0;
  logic        valid = 1'b0, finish = 1'b0, ts_ready = 1'b0, ovf_clr = 1'b0;
  logic [22:0] ts_data;
  logic        ts_valid, overflow, proto_err, busy;
  logic [7:0]  drop_cnt;
  always #5 clk = ~clk;
  stop_timestamp_encoder dut (
    .clk(clk), .rst_n(rst_n), .therm(therm), .valid(valid), .finish(finish),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready), .overflow(overflow),
    .ovf_clr(ovf_clr), .proto_err(proto_err), .drop_cnt(drop_cnt), .busy(busy)
  );
  typedef struct {int wr_t; logic [22:0] w;} pend_t;
  typedef struct {logic [63:0] th; logic [6:0] f_hsb; logic [6:0] f_pop;} vec_t;
  logic [22:0] mq[$];
  pend_t       pend[$];
  int          t, acc_t, free_t, m_drop, n_vec, n_bad;
  bit          waiting, m_ovf, m_perr;
  function automatic logic [6:0] fine_of(logic [63:0] th);
    int f = 0;
`ifdef STOP_BUBBLE_CORR_EN
    f = $countones(th);
`else
    while (f < 64 && (th >> f) != 0) f++;
`endif
    return 7'(f);
  endfunction
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask
  task automatic model_reset();
    mq.delete(); pend.delete();
    t = 0; acc_t = 0; free_t = 0; m_drop = 0; waiting = 0; m_ovf = 0; m_perr = 0;
  endtask
  // one clock of the reference behaviour, using the inputs currently driven
  task automatic model_step();
    bit pop, acc, novf;
    pend_t p;
    pop  = mq.size() > 0 && ts_ready;
    acc  = valid && !waiting && t >= free_t;
    novf = 0;
    if (valid && !acc && m_drop < 255) m_drop++;
    if (waiting && (finish || t == acc_t + 2)) begin
      if (!finish) m_perr = 1;
      free_t = t + 1 + HOLDOFF;
      waiting = 0;
    end
    if (acc) begin
      waiting = 1; acc_t = t;
      pend.push_back('{t + 2, {16'(t - 1), fine_of(therm)}});
    end
    if (pop) void'(mq.pop_front());
    if (pend.size() > 0 && pend[0].wr_t == t) begin
      p = pend.pop_front();
      if (mq.size() < DEPTH) mq.push_back(p.w); else novf = 1;
    end
    m_ovf = novf ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    t++;
  endtask
  task automatic check_all();
    cmp("ts_valid", ts_valid, mq.size() > 0);
    if (mq.size() > 0) cmp("ts_data", ts_data, mq[0]);
    cmp("overflow", overflow, m_ovf);
    cmp("proto_err", proto_err, m_perr);
    cmp("drop_cnt", drop_cnt, m_drop);
    cmp("busy", busy, waiting || t < free_t);
  endtask
  task automatic tick(input logic v, input logic f, input logic [63:0] th, input logic rdy, input logic clr);
    valid = v; finish = f; therm = th; ts_ready = rdy; ovf_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(0, 0, '0, rdy, 0);
  endtask
  task automatic hit(input logic [63:0] th, input logic rdy);
    tick(1, 0, th, rdy, 0);
    tick(0, 1, '0, rdy, 0);
    idle(8, rdy);
  endtask
  task automatic do_reset();
    @(negedge clk);
    valid = 0; finish = 0; ts_ready = 0; ovf_clr = 0; therm = '0;
    rst_n = 1'b0;
    #1;
    cmp("rst_ts_valid", ts_valid, 0);
    cmp("rst_ts_data", ts_data, 0);
    cmp("rst_overflow", overflow, 0);
    cmp("rst_proto_err", proto_err, 0);
    cmp("rst_drop_cnt", drop_cnt, 0);
    cmp("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    vec_t vt[8];
    int d0;
    vt[0] = '{64'h0, 7'd0, 7'd0};
    vt[1] = '{64'h0000_0000_0000_FFFF, 7'd16, 7'd16};
    vt[2] = '{64'h0000_0000_0000_F7FF, 7'd16, 7'd15};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 7'd64};
    vt[4] = '{64'h1, 7'd1, 7'd1};
    vt[5] = '{64'h8000_0000_0000_0000, 7'd64, 7'd1};
    vt[6] = '{64'h5, 7'd3, 7'd2};
    vt[7] = '{64'h0000_00FF_FFFF_FFFF, 7'd40, 7'd40};
    n_vec = 0; n_bad = 0;
    model_reset();
    do_reset();
    idle(20, 1);
    while (t < 100) tick(0, 0, '0, 1, 0);
    tick(1, 0, 64'h0000_0000_0000_FFFF, 1, 0);
    tick(0, 1, '0, 1, 0);
    tick(0, 0, '0, 1, 0);
    cmp("single_valid", ts_valid, 1);
    cmp("single_data", ts_data, {16'd99, 7'd16});
    tick(0, 0, '0, 1, 0);
    cmp("single_pulse_end", ts_valid, 0);
    idle(6, 1);
    foreach (vt[i]) begin
      tick(1, 0, vt[i].th, 1, 0);
      tick(0, 1, '0, 1, 0);
      tick(0, 0, '0, 1, 0);
`ifdef STOP_BUBBLE_CORR_EN
      cmp("tbl_fine", ts_data[6:0], vt[i].f_pop);
`else
      cmp("tbl_fine", ts_data[6:0], vt[i].f_hsb);
`endif
      idle(8, 1);
    end
    for (int i = 0; i < 5; i++) hit(64'h3 << i, 0);
    cmp("bp_ovf_set", overflow, 1);
    cmp("bp_held", ts_valid, 1);
    tick(0, 0, '0, 0, 1);
    cmp("bp_ovf_clr", overflow, 0);
    idle(6, 1);
    cmp("bp_drained", ts_valid, 0);
    for (int i = 0; i < 4; i++) hit(64'hF << i, 0);
    tick(1, 0, 64'hFF, 0, 0);
    tick(0, 1, '0, 0, 0);
    tick(0, 0, '0, 1, 0);
    cmp("full_pushpop_no_ovf", overflow, 0);
    idle(8, 0);
    tick(1, 0, 64'h1FF, 0, 0);
    tick(0, 1, '0, 0, 0);
    tick(0, 0, '0, 0, 1);
    cmp("ovf_set_wins", overflow, 1);
    tick(0, 0, '0, 1, 1);
    idle(8, 1);
    d0 = m_drop;
    tick(1, 0, 64'h7, 1, 0);
    tick(0, 1, '0, 1, 0);
    tick(0, 0, '0, 1, 0);
    tick(1, 0, 64'hFFFF, 1, 0);
    cmp("dead_drop", drop_cnt, d0 + 1);
    idle(3, 1);
    tick(1, 0, 64'h3F, 1, 0);
    cmp("dead_accept", busy, 1);
    cmp("dead_no_extra_drop", drop_cnt, d0 + 1);
    tick(0, 1, '0, 1, 0);
    idle(8, 1);
    tick(1, 0, 64'hFF, 1, 0);
    tick(0, 0, '0, 1, 0);
    tick(0, 0, '0, 1, 0);
    cmp("perr_set", proto_err, 1);
    cmp("perr_word", ts_valid, 1);
    idle(4, 1);
    cmp("perr_idle", busy, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] th;
      th = ($urandom_range(0, 1) != 0) ? ((64'h1 << $urandom_range(0, 63)) - 64'h1)
                                       : {$urandom, $urandom};
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0, th,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 600; i++) tick(1, 0, 64'hFF, 1, 0);
    cmp("drop_sat", drop_cnt, 255);
    idle(10, 1);
    hit(64'h3, 0);
    hit(64'h7, 0);
    tick(1, 0, 64'hF, 0, 0);
    do_reset();
    tick(1, 0, 64'h0000_0000_0000_FFFF, 1, 0);
    tick(0, 1, '0, 1, 0);
    tick(0, 0, '0, 1, 0);
    cmp("wrap_valid", ts_valid, 1);
    cmp("wrap_coarse", ts_data[22:7], 16'hFFFF);
    idle(8, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
